md_ctrl: RTL

- Multiply/divide sequencer for the EX stage. Owns the HI/LO registers and models MULT/MULTU/DIV/DIVU as multi-cycle operations using a busy counter.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Raises a stall request to the hazard logic whenever the instruction in ID uses HI/LO while an operation is starting or in flight.
- Sits beside the ALU in EX. Operands are the already-forwarded rs/rt values of the EX pipeline register.

---
 rtl/md_ctrl_pkg.sv | 33 +++
 rtl/md_ctrl_arith.sv | 74 +++++++
 rtl/md_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared md-class operation codes and default busy-cycle counts
// Revision: 1.0
`default_nettype none

package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return (op >= 4'(MD_MULT)) && (op <= 4'(MD_MFLO));
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_ctrl_arith.sv
// md_arith: combinational 32x32 multiply / divide producing HI and LO
// Revision: 1.0
`default_nettype none

module md_arith
  import md_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               sdiv;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] divisor;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic               q_neg;
  logic               r_neg;
  logic        [31:0] quot;
  logic        [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division goes through magnitudes so truncation toward zero and the
  // 0x80000000 / -1 overflow case fall out without relying on signed '/' semantics.
  assign sdiv    = (op == MD_DIV);
  assign mag_a   = (sdiv && a[31]) ? (~a + 32'd1) : a;
  assign mag_b   = (sdiv && b[31]) ? (~b + 32'd1) : b;
  assign divisor = (b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag   = mag_a / divisor;
  assign r_mag   = mag_a % divisor;
  assign q_neg   = sdiv && (a[31] ^ b[31]);
  assign r_neg   = sdiv && a[31];
  assign quot    = q_neg ? (~q_mag + 32'd1) : q_mag;
  assign rem     = r_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage multiply/divide sequencer owning HI/LO, with ID stall request
// Revision: 1.0
`default_nettype none

module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             idle;
  logic             start;
  logic             is_mul;

  md_arith u_arith (
    .op     (md_op),
    .a      (src_a),
    .b      (src_b),
    .res_hi (arith_hi),
    .res_lo (arith_lo)
  );

  assign idle     = (cnt == '0);
  assign start    = is_muldiv(md_op) && idle;
  assign is_mul   = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign load_val = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  assign stall_req = id_md_use && (start || busy);

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == MD_MFHI) begin
      md_rdata = hi;
    end else if (md_op == MD_MFLO) begin
      md_rdata = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (start) begin
      cnt     <= load_val;
      busy    <= 1'b1;
      pend_hi <= arith_hi;
      pend_lo <= arith_lo;
    end else if (!idle) begin
      // Ops arriving mid-flight are dropped; the result lands on the 1 -> 0 edge.
      cnt  <= cnt - 1'b1;
      busy <= (cnt != CNT_W'(1));
      if (cnt == CNT_W'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (md_op == MD_MTHI) begin
        hi <= src_a;
      end
      if (md_op == MD_MTLO) begin
        lo <= src_a;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_md_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(busy && is_md(md_op)));
`endif

endmodule

`default_nettype wire
